// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults, index-width helper and entry-index type for
//               the register-array FIFO read-side logic.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEPTH_DEFAULT = 4;
    localparam int c_WIDTH_DEFAULT = 8;

    // Smallest index width that addresses depth entries (never below 1 bit).
    function automatic int calc_aw(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int c_AW_DEFAULT = calc_aw(c_DEPTH_DEFAULT);

    typedef logic [c_AW_DEFAULT-1:0] entry_idx_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/onehot_enc.sv
`default_nettype none
// ============================================================================
// Module      : onehot_enc
// Description : Lowest-set-bit priority encoder; inverse of the entry-select
//               decoder. o_none flags an all-zero input.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_enc
    import fifo_pkg::*;
#(
    parameter int N  = c_DEPTH_DEFAULT,
    parameter int AW = calc_aw(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [AW-1:0] o_idx,
    output logic          o_none
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx  = AW'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule : onehot_enc
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : FIFO read-side controller: encodes one-hot write strobes,
//               tracks entry occupancy and drains entries in pointer order
//               through a registered valid/ready port.
//               Optional macro FIFO_RD_ONEHOT_CHECK_EN adds a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEPTH-1:0]       wr_sel,
    input  logic [DEPTH*WIDTH-1:0] entries,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [DEPTH-1:0]       occ,
    output logic                   full,
    output logic                   empty,
    output logic [AW-1:0]          wr_idx,
    output logic                   err
);

    logic [DEPTH-1:0] r_occ;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_idx;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;

    logic [AW-1:0]    w_enc_idx;
    logic             w_enc_none;
    logic             w_wr_accept;
    logic             w_load;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [AW-1:0]    w_rd_ptr_nxt;

    onehot_enc #(
        .N  (DEPTH),
        .AW (AW)
    ) u_enc (
        .i_vec  (wr_sel),
        .o_idx  (w_enc_idx),
        .o_none (w_enc_none)
    );

    // A write aimed at an entry whose flag is still set is dropped, including
    // the entry being loaded this very edge.
    assign w_wr_accept  = !w_enc_none && !r_occ[w_enc_idx];
    assign w_load       = (!r_rd_valid || rd_ready) && r_occ[r_rd_ptr];
    assign w_set        = w_wr_accept ? (DEPTH'(1) << w_enc_idx) : '0;
    assign w_clr        = w_load ? (DEPTH'(1) << r_rd_ptr) : '0;
    assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_wr_idx   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_occ <= (r_occ & ~w_clr) | w_set;
            if (w_wr_accept) begin
                r_wr_idx <= w_enc_idx;
            end
            if (w_load) begin
                r_rd_data  <= entries[r_rd_ptr*WIDTH +: WIDTH];
                r_rd_valid <= 1'b1;
                r_rd_ptr   <= w_rd_ptr_nxt;
            end else if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign occ      = r_occ;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign wr_idx   = r_wr_idx;
    assign full     = &r_occ;
    assign empty    = (r_occ == '0) && !r_rd_valid;

`ifdef FIFO_RD_ONEHOT_CHECK_EN
    logic r_err;
    logic w_multi;
    logic w_drop;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_multi = |(wr_sel & (wr_sel - DEPTH'(1)));
    assign w_drop  = !w_enc_none && r_occ[w_enc_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_multi | w_drop;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule : fifo_rd_ctrl
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Scoreboard bench for fifo_rd_ctrl (DEPTH=4, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

`ifdef FIFO_RD_ONEHOT_CHECK_EN
    localparam logic c_ERR_EN = 1'b1;
`else
    localparam logic c_ERR_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [DEPTH-1:0]       wr_sel;
    logic [DEPTH*WIDTH-1:0] entries;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [WIDTH-1:0]       rd_data;
    logic [DEPTH-1:0]       occ;
    logic                   full;
    logic                   empty;
    logic [AW-1:0]          wr_idx;
    logic                   err;

    int n_checks;
    int n_errors;
    logic [WIDTH-1:0] r_exp_q[$];

    fifo_rd_ctrl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_sel   (wr_sel),
        .entries  (entries),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .occ      (occ),
        .full     (full),
        .empty    (empty),
        .wr_idx   (wr_idx),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of the storage array is the word that entry k delivers.
    function automatic logic [WIDTH-1:0] word_of(input int k);
        return entries[k*WIDTH +: WIDTH];
    endfunction

    task automatic write_entry(input int k);
        wr_sel = DEPTH'(1) << k;
        tick();
        wr_sel = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (r_exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, r_exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r_exp_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    // Every accepted word is popped from the scoreboard in arrival order.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (r_exp_q.size() == 0) begin
                chk("rd_unexpected", rd_data, 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", rd_data, r_exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        entries  = 32'h4433_2211;
        wr_sel   = '0;
        rd_ready = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        chk("rst_occ", occ, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_idx", wr_idx, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // In-order drain at full throughput.
        rd_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            r_exp_q.push_back(word_of(k));
            wr_sel = DEPTH'(1) << k;
            tick();
            chk("drain_wr_idx", wr_idx, k);
            chk("drain_valid", rd_valid, (k >= 1) ? 1 : 0);
        end
        wr_sel = '0;
        tick();
        chk("drain_last_valid", rd_valid, 1);
        chk("drain_last_data", rd_data, 8'h44);
        drain("drain_timeout");
        chk("drain_empty", empty, 1);

        // Backpressure: entry 0 moves into the output register, so a second
        // write to entry 0 is needed before all four flags are set.
        rd_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            r_exp_q.push_back(word_of(k));
            write_entry(k);
        end
        chk("bp_not_full", full, 0);
        r_exp_q.push_back(word_of(0));
        write_entry(0);
        chk("bp_full", full, 1);
        tick();
        tick();
        chk("bp_hold_data", rd_data, 8'h11);
        chk("bp_hold_valid", rd_valid, 1);
        chk("bp_hold_full", full, 1);
        rd_ready = 1'b1;
        drain("bp_timeout");
        chk("bp_empty", empty, 1);
        chk("bp_occ", occ, 0);

        // Mid-stream asynchronous reset with a word waiting in the register.
        rd_ready = 1'b0;
        write_entry(1);
        write_entry(2);
        tick();
        chk("pre_rst_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_occ", occ, 0);
        chk("arst_empty", empty, 1);
        chk("arst_err", err, 0);
        r_exp_q.delete();
        tick();
        rst_n = 1'b1;

        // Gap stall: entry 1 alone cannot leave while rd_ptr points at 0.
        rd_ready = 1'b1;
        write_entry(1);
        tick();
        tick();
        chk("gap_stall_valid", rd_valid, 0);
        chk("gap_occ", occ, 4'b0010);
        r_exp_q.push_back(8'h11);
        r_exp_q.push_back(8'h22);
        write_entry(0);
        drain("gap_timeout");
        chk("gap_empty", empty, 1);

        // Duplicate write to an occupied entry is dropped.
        do_reset();
        rd_ready = 1'b0;
        write_entry(2);
        chk("dup_first_err", err, 0);
        write_entry(2);
        chk("dup_occ", occ, 4'b0100);
        chk("dup_wr_idx", wr_idx, 2);
        chk("dup_err", err, c_ERR_EN);
        tick();
        chk("dup_err_sticky", err, c_ERR_EN);

        // Multi-hot strobe: only the lowest set bit is honoured.
        do_reset();
        wr_sel = 4'b0110;
        tick();
        wr_sel = '0;
        chk("mh_occ", occ, 4'b0010);
        chk("mh_wr_idx", wr_idx, 1);
        chk("mh_err", err, c_ERR_EN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_rd_ctrl
`default_nettype wire
